// File: rtl/fp16_pkg.sv
// Shared half-precision definitions used by the multiplier wrapper and its
// result buffer.
package fp16_pkg;

  localparam int EXPONENT       = 5;
  localparam int MANTISSA       = 10;
  localparam int DWIDTH         = 1 + EXPONENT + MANTISSA;
  localparam int FPMULT_LATENCY = 5;
  localparam int FLAG_W         = 5;

  // One buffered multiplier output: product plus its exception flags.
  typedef struct packed {
    logic [DWIDTH-1:0] result;
    logic [FLAG_W-1:0] flags;
  } fp_entry_t;

endpackage

// File: rtl/fpmult_result_fifo.sv
// Circular-buffer FIFO with occupancy count. The head entry is presented
// combinationally; storage is cleared by reset so the head reads zero when
// nothing has been written yet.
module fpmult_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;
  logic [DEPTH-1:0] wr_sel;

  // Pushes into a full buffer and pops from an empty one are dropped.
  assign push_ok = push_i && (count_q != FULL);
  assign pop_ok  = pop_i && (count_q != '0);

  // One-hot write-enable per storage slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push_ok && (wr_ptr_q == AW'(gi));
    end
  endgenerate

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Storage, pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem_q[i] <= wr_data_i;
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fpmult_stream_ctrl.sv
// Valid/ready wrapper around the stall-free half-precision multiplier.
// Credits reserve a FIFO slot for every accepted op, so results emerging
// from the fixed-latency pipeline always have somewhere to land.
module fpmult_stream_ctrl
  import fp16_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int LATENCY    = FPMULT_LATENCY,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic [DWIDTH-1:0] mul_a,
  output logic [DWIDTH-1:0] mul_b,
  input  logic [DWIDTH-1:0] mul_result,
  input  logic [4:0]        mul_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_result,
  output logic [4:0]        out_flags,
  output logic [4:0]        sticky_flags,
  input  logic              clear_sticky,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DWIDTH + FLAG_W;
  localparam logic [CW-1:0] CREDITS_FULL = CW'(FIFO_DEPTH);

  logic [CW-1:0]      credits_q, credits_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [FLAG_W-1:0]  sticky_q, sticky_d;
  logic               accept, push, pop;
  logic [EW-1:0]      head;
  logic [CW-1:0]      fifo_count;

  // Ready comes only from the registered credit count, never from out_ready.
  assign in_ready = (credits_q != '0);
  assign accept   = in_valid && in_ready;
  assign push     = vld_q[LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign pop      = out_valid && out_ready;
  assign busy     = (credits_q != CREDITS_FULL);

  // Bubbles feed +0 x +0 so idle cycles do not toggle the datapath.
  assign mul_a = accept ? in_a : '0;
  assign mul_b = accept ? in_b : '0;

  // Credit update: a credit is taken on accept and returned on pop.
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !accept) credits_d = credits_q + CW'(1);
  end

  // Delay line shifting accept alongside the multiplier pipeline.
  always_comb begin
    vld_d = '0;
    vld_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  // Clear drops previous history; a same-cycle push still gets recorded.
  always_comb begin
    sticky_d = (clear_sticky ? '0 : sticky_q) | (push ? mul_flags : '0);
  end

  // Registered state: credits, delay line and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CREDITS_FULL;
      vld_q     <= '0;
      sticky_q  <= '0;
    end else begin
      credits_q <= credits_d;
      vld_q     <= vld_d;
      sticky_q  <= sticky_d;
    end
  end

  fpmult_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i ({mul_result, mul_flags}),
    .rd_data_o (head),
    .count_o   (fifo_count)
  );

  assign out_result   = head[EW-1:FLAG_W];
  assign out_flags    = head[FLAG_W-1:0];
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fpmult_stream_ctrl.sv
// Bench for fpmult_stream_ctrl: a behavioural FP16 multiplier stub drives the
// result side, and a queue-based model predicts every handshake output.
module tb_fpmult_stream_ctrl;

  localparam int DW    = 16;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0, clear_sticky = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          in_ready, out_valid, busy;
  logic [DW-1:0] mul_a, mul_b, mul_result, out_result;
  logic [4:0]    mul_flags, out_flags, sticky_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpmult_stream_ctrl #(.DWIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_result   (mul_result),
    .mul_flags    (mul_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clear_sticky (clear_sticky),
    .busy         (busy)
  );

  // Simplified FP16 multiply: subnormals flush to zero, mantissa truncated.
  // Flag bits: 0 inexact, 1 underflow, 2 overflow.
  function automatic logic [20:0] fpm(input logic [15:0] a, input logic [15:0] b);
    logic s; int e; logic [21:0] m; logic [9:0] man; logic inx;
    logic [15:0] r; logic [4:0] f;
    s = a[15] ^ b[15];
    f = '0;
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
      r = {s, 15'd0};
    end else begin
      m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (m[21]) begin e++; man = m[20:11]; inx = (m[10:0] != 0); end
      else begin man = m[19:10]; inx = (m[9:0] != 0); end
      if (e >= 31)     begin r = {s, 5'h1f, 10'd0}; f = 5'b00101; end
      else if (e <= 0) begin r = {s, 15'd0};        f = 5'b00011; end
      else             begin r = {s, e[4:0], man};  f = {4'd0, inx}; end
    end
    return {r, f};
  endfunction

  // Multiplier stub: LAT-stage pipeline sharing clock and reset.
  logic [20:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fpm(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_result = pipe[LAT-1][20:5];
  assign mul_flags  = pipe[LAT-1][4:0];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in-order list of outstanding ops, each with the cycle
  // its result becomes visible at the FIFO head.
  typedef struct {
    int          vis;
    logic [15:0] r;
    logic [4:0]  f;
  } ent_t;

  ent_t        sb[$];
  ent_t        ent;
  logic [15:0] popped[$];
  logic [4:0]  m_sticky = '0;
  int          cyc = 0;
  bit          ev, acc, pp;
  logic [4:0]  pf;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_sticky = '0;
    end else begin
      ev = (sb.size() > 0) && (sb[0].vis <= cyc);
      chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("out_result", 32'(out_result), 32'(sb[0].r));
        chk("out_flags", 32'(out_flags), 32'(sb[0].f));
      end
      chk("sticky", 32'(sticky_flags), 32'(m_sticky));
      acc = in_valid && (sb.size() < DEPTH);
      chk("mul_a", 32'(mul_a), acc ? 32'(in_a) : 32'd0);
      chk("mul_b", 32'(mul_b), acc ? 32'(in_b) : 32'd0);
      chk("fifo_no_overflow", 32'(dut.u_fifo.count_o <= DEPTH), 32'd1);
      pp = ev && out_ready;
      pf = '0;
      foreach (sb[i]) if (sb[i].vis == cyc + 1) pf = sb[i].f;
      m_sticky = (clear_sticky ? 5'd0 : m_sticky) | pf;
      if (pp) begin
        popped.push_back(out_result);
        void'(sb.pop_front());
      end
      if (acc) begin
        ent.vis = cyc + LAT + 1;
        {ent.r, ent.f} = fpm(in_a, in_b);
        sb.push_back(ent);
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && busy; k++) step();
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_acc;
  int idx;
  bit a_rdy;

  initial begin
    // Pin the behavioural multiplier with hand-computed products.
    chk("model_1p5x2", 32'(fpm(16'h3E00, 16'h4000)), 32'({16'h4200, 5'h00}));
    chk("model_ovf", 32'(fpm(16'h7BFF, 16'h7BFF)), 32'({16'h7C00, 5'h05}));
    chk("model_inx", 32'(fpm(16'h3C01, 16'h3C01)), 32'({16'h3C02, 5'h01}));

    // Reset values.
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);

    // Single op: accepted at cycle 0, visible at cycle 6.
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h4000;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("single_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_result", 32'(out_result), 32'h4200);
    chk("single_flags", 32'(out_flags), 32'd0);
    step();
    chk("single_busy_low", 32'(busy), 32'd0);

    // Backpressure fill: 10 offered, only DEPTH accepted.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
      if (in_ready) n_acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepts", 32'(n_acc), 32'(DEPTH));
    repeat (LAT + 2) step();
    chk("bp_count", 32'(dut.u_fifo.count_o), 32'(DEPTH));
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);

    // Pop at zero credits with in_valid held.
    in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4400;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("zc_ready_after_pop", 32'(in_ready), 32'd1);
    step();
    chk("zc_ready_refilled", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (LAT + 2) step();
    chk("zc_count", 32'(dut.u_fifo.count_o), 32'(DEPTH));
    drain();

    // Wrap and order: 1.0 x B must return B, in order.
    popped.delete();
    idx = 0;
    for (int k = 0; k < 400 && idx < 20; k++) begin
      in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'(16'h3C00 + idx * 16);
      out_ready = 1'($urandom_range(0, 1));
      a_rdy = in_ready;
      step();
      if (a_rdy) idx++;
    end
    chk("wrap_issued", 32'(idx), 32'd20);
    drain();
    chk("wrap_popped", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      chk($sformatf("wrap_order_%0d", i), 32'(popped[i]), 32'(16'h3C00 + i * 16));

    // Sticky flags.
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    in_valid = 1'b1; in_a = 16'h3C01; in_b = 16'h3C01;
    step();
    in_valid = 1'b0;
    drain();
    chk("sticky_inexact", 32'(sticky_flags), 32'h01);
    in_valid = 1'b1; in_a = 16'h7BFF; in_b = 16'h7BFF;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    chk("sticky_clear_on_push", 32'(sticky_flags), 32'h05);
    drain();
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    chk("sticky_cleared", 32'(sticky_flags), 32'h00);

    // Random traffic checked by the model.
    for (int k = 0; k < 300; k++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_a         = 16'($urandom);
      in_b         = 16'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      clear_sticky = ($urandom_range(0, 15) == 0);
      step();
    end
    clear_sticky = 1'b0;
    drain();

    // Reset mid-flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'h4000; in_b = 16'(16'h3C00 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("rstmid_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
